// File: rtl/axis_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_out_fifo                                                   |
// | Purpose  : 64-bit AXI-Stream output FIFO with a registered head beat and   |
// |            an optional packet mode that holds the output until a whole     |
// |            frame (or a full FIFO) is buffered.                             |
// | Ports    : clk/rst         - clock, synchronous active-high reset          |
// |            pkt_mode        - 1 = release output only on complete frames    |
// |            s_valid/s_data/s_last/s_ready - upstream beat interface         |
// |            m_valid/m_data/m_last/m_strb/m_ready - downstream interface     |
// |            level           - beats held, including the presented one      |
// |            frames_out      - frames completed at the output (wraps)        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module axis_out_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pkt_mode,
  input  logic             s_valid,
  input  logic [63:0]      s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             m_valid,
  output logic [63:0]      m_data,
  output logic             m_last,
  output logic [7:0]       m_strb,
  input  logic             m_ready,
  output logic [LVL_W-1:0] level,
  output logic [15:0]      frames_out
);

  localparam int               c_PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] c_FULL  = LVL_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Storage: bit 64 is the last flag, bits 63:0 the data.
  logic [64:0]        r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [LVL_W-1:0]   r_lasts;
  logic [15:0]        r_frames;
  logic [63:0]        r_m_data;
  logic               r_m_last;
  state_t             r_state;

  logic               w_push;
  logic               w_pop;
  logic [LVL_W-1:0]   w_level_nxt;
  logic [LVL_W-1:0]   w_lasts_nxt;
  logic [LVL_W-1:0]   w_remain;
  logic [c_PTR_W-1:0] w_rd_ptr_nxt;
  logic               w_start;
  state_t             w_state_nxt;

  // Only registered state and rst feed s_ready; m_ready never does, so a
  // full FIFO refuses a beat even in a cycle where it is also popping.
  assign s_ready = ~rst & (r_level != c_FULL);
  assign m_valid = (r_state == ST_SEND);
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;
  assign m_strb  = 8'hFF;
  assign level   = r_level;
  assign frames_out = r_frames;

  assign w_push       = s_valid & s_ready;
  assign w_pop        = m_valid & m_ready;
  assign w_level_nxt  = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
  assign w_remain     = r_level - LVL_W'(w_pop);
  assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(w_pop);

  always_comb begin
    w_lasts_nxt = r_lasts;
    case ({w_push & s_last, w_pop & r_m_last})
      2'b10:   w_lasts_nxt = r_lasts + LVL_W'(1);
      2'b01:   w_lasts_nxt = r_lasts - LVL_W'(1);
      default: w_lasts_nxt = r_lasts;
    endcase
  end

  // Start condition is judged on next-cycle occupancy so a beat pushed into
  // an empty FIFO is presented with m_valid on the very next cycle.
  assign w_start = pkt_mode ? ((w_lasts_nxt != '0) || (w_level_nxt == c_FULL))
                            : (w_level_nxt != '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (w_level_nxt == '0)
          w_state_nxt = ST_IDLE;
        else if (w_pop && r_m_last && !w_start)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_last, s_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_lasts  <= '0;
      r_frames <= '0;
      r_m_data <= '0;
      r_m_last <= 1'b0;
      r_state  <= ST_IDLE;
    end else begin
      r_state  <= w_state_nxt;
      r_level  <= w_level_nxt;
      r_lasts  <= w_lasts_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop && r_m_last) r_frames <= r_frames + 16'd1;
      // Head register mirrors the oldest stored beat. When the FIFO would
      // otherwise be empty, the incoming beat is bypassed straight into it
      // because its memory write lands on this same edge.
      if (w_remain != '0) begin
        r_m_data <= r_mem[w_rd_ptr_nxt][63:0];
        r_m_last <= r_mem[w_rd_ptr_nxt][64];
      end else if (w_push) begin
        r_m_data <= s_data;
        r_m_last <= s_last;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axis_out_fifo                                                |
// | Purpose  : Self-checking bench for axis_out_fifo: directed scenarios plus  |
// |            random traffic compared with a queue-based reference model.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_axis_out_fifo;

  localparam int DEPTH = 16;
  localparam int LVL_W = 5;

  logic             clk;
  logic             rst;
  logic             pkt_mode;
  logic             s_valid;
  logic [63:0]      s_data;
  logic             s_last;
  logic             s_ready;
  logic             m_valid;
  logic [63:0]      m_data;
  logic             m_last;
  logic [7:0]       m_strb;
  logic             m_ready;
  logic [LVL_W-1:0] level;
  logic [15:0]      frames_out;

  axis_out_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_mode   (pkt_mode),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_strb     (m_strb),
    .m_ready    (m_ready),
    .level      (level),
    .frames_out (frames_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: buffered beats as {last, data}, output gate, frame count.
  logic [64:0] mdl_q[$];
  bit          mdl_send;
  logic [15:0] mdl_frames;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int mdl_lasts();
    int n = 0;
    foreach (mdl_q[i]) if (mdl_q[i][64]) n++;
    return n;
  endfunction

  // One clock cycle: drive inputs at the negedge, check s_ready, advance the
  // model across the posedge, then check the registered outputs at the next
  // negedge.
  task automatic cycle(input logic sv, input logic [63:0] sd, input logic sl,
                       input logic mr, input logic pm, input logic rs);
    logic        exp_ready;
    logic        push;
    logic        pop;
    logic        popped_last;
    logic        start;
    logic [64:0] popped;
    s_valid  = sv;
    s_data   = sd;
    s_last   = sl;
    m_ready  = mr;
    pkt_mode = pm;
    rst      = rs;
    #1;
    exp_ready = !rs && (mdl_q.size() != DEPTH);
    check("s_ready", 64'(s_ready), 64'(exp_ready));
    if (rs) begin
      mdl_q.delete();
      mdl_send   = 1'b0;
      mdl_frames = 16'd0;
    end else begin
      push        = sv && exp_ready;
      pop         = mdl_send && mr;
      popped_last = 1'b0;
      if (pop) begin
        popped      = mdl_q.pop_front();
        popped_last = popped[64];
        if (popped_last) mdl_frames = mdl_frames + 16'd1;
      end
      if (push) mdl_q.push_back({sl, sd});
      start = pm ? ((mdl_lasts() != 0) || (mdl_q.size() == DEPTH)) : (mdl_q.size() != 0);
      if (!mdl_send)
        mdl_send = start;
      else if ((mdl_q.size() == 0) || (popped_last && !start))
        mdl_send = 1'b0;
    end
    @(negedge clk);
    check("m_valid", 64'(m_valid), 64'(mdl_send));
    check("level", 64'(level), 64'(mdl_q.size()));
    check("frames_out", 64'(frames_out), 64'(mdl_frames));
    if (mdl_send) begin
      check("m_data", m_data, mdl_q[0][63:0]);
      check("m_last", 64'(m_last), 64'(mdl_q[0][64]));
    end
  endtask

  initial begin
    logic pm_r;
    logic mr_r;
    int   mr_pct;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    m_ready  = 1'b0;
    pkt_mode = 1'b0;
    rst      = 1'b1;
    mdl_send   = 1'b0;
    mdl_frames = 16'd0;
    @(negedge clk);

    // Reset state
    cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("m_strb", 64'(m_strb), 64'hFF);

    // Single beat latency
    cycle(1'b1, 64'h1111_1111_1111_1111, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lat_valid", 64'(m_valid), 64'd1);
    check("lat_data", m_data, 64'h1111_1111_1111_1111);
    cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lat_level", 64'(level), 64'd0);

    // Fill to full with output stalled, 17th beat refused, then drain
    for (int i = 0; i < 17; i++) cycle(1'b1, 64'hA000 + 64'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_level", 64'(level), 64'd16);
    check("full_ready", 64'(s_ready), 64'd0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("drain_level", 64'(level), 64'd0);

    // Packet mode holds until the last beat arrives
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 64'hB000 + 64'(i), 1'b0, 1'b1, 1'b1, 1'b0);
      check("pkt_hold", 64'(m_valid), 64'd0);
    end
    cycle(1'b1, 64'hB003, 1'b1, 1'b1, 1'b1, 1'b0);
    check("pkt_release", 64'(m_valid), 64'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("pkt_frames", 64'(frames_out), 64'd1);

    // Continuous streaming, last every 8th beat
    cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 64'hC000 + 64'(i), (i % 8) == 7, 1'b1, 1'b0, 1'b0);
      check("stream_level", 64'(level), 64'd1);
      check("stream_valid", 64'(m_valid), 64'd1);
    end
    cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stream_frames", 64'(frames_out), 64'd12);

    // Random traffic with varying backpressure and mode changes
    pm_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) == 199) pm_r = ~pm_r;
      case ((i / 250) % 3)
        0:       mr_pct = 90;
        1:       mr_pct = 50;
        default: mr_pct = 10;
      endcase
      mr_r = ($urandom_range(0, 99) < mr_pct);
      cycle($urandom_range(0, 3) != 0, {$urandom(), $urandom()},
            $urandom_range(0, 4) == 0, mr_r, pm_r, 1'b0);
    end

    // frames_out wrap after 65536 frames
    cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65536; i++) cycle(1'b1, 64'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    check("wrap_ffff", 64'(frames_out), 64'hFFFF);
    cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap_zero", 64'(frames_out), 64'd0);

    // Reset in the middle of a frame
    cycle(1'b1, 64'hD0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'hE000 + 64'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_level", 64'(level), 64'd5);
    cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    check("mid_rst_frames", 64'(frames_out), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("post_rst_valid", 64'(m_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
